// File: rtl/freq_meter_gated.sv
// Gated frequency / period meter for an asynchronous pulse train.
// Frequency mode counts edges per gate window; period mode counts clk cycles between edges.
module freq_meter_gated #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse,
    input  logic              enable,
    input  logic              mode,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  N,
    output logic              valid,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_t              state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                sync_prev, edge_det;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc, n_q, n_n;
    logic [GATE_W-1:0]   gate_cnt, gate_n, gate_load;
    logic                mode_q, mode_n;
    logic                ovf, ovf_n, ovf_inc;
    logic                ovf_q, ovf_out_n, valid_n;

    // Synchroniser chain followed by a single edge-detect flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det  = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign cnt_inc   = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    assign ovf_inc   = ovf | (cnt == CNT_MAX);
    assign gate_load = (gate_len == '0) ? GATE_ONE : gate_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            gate_cnt <= '0;
            mode_q   <= 1'b0;
            ovf      <= 1'b0;
            n_q      <= '0;
            ovf_q    <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            gate_cnt <= gate_n;
            mode_q   <= mode_n;
            ovf      <= ovf_n;
            n_q      <= n_n;
            ovf_q    <= ovf_out_n;
            valid    <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gate_n    = gate_cnt;
        mode_n    = mode_q;
        ovf_n     = ovf;
        n_n       = n_q;
        ovf_out_n = ovf_q;
        valid_n   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    mode_n = mode;
                    cnt_n  = '0;
                    ovf_n  = 1'b0;
                    if (!mode) begin
                        state_n = MEASURE;
                        gate_n  = gate_load;
                    end else begin
                        state_n = ARM;
                    end
                end
            end
            ARM: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (edge_det) begin
                    state_n = MEASURE;
                    cnt_n   = CNT_ONE;
                    ovf_n   = 1'b0;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (!mode_q) begin
                    if (edge_det) begin
                        cnt_n = cnt_inc;
                        ovf_n = ovf_inc;
                    end
                    gate_n = gate_cnt - GATE_ONE;
                    // Last gate cycle: publish (including this cycle's edge) and reopen with no gap.
                    if (gate_cnt == GATE_ONE) begin
                        n_n       = cnt_n;
                        ovf_out_n = ovf_n;
                        valid_n   = 1'b1;
                        cnt_n     = '0;
                        ovf_n     = 1'b0;
                        gate_n    = gate_load;
                    end
                end else begin
                    if (edge_det) begin
                        n_n       = cnt;
                        ovf_out_n = ovf;
                        valid_n   = 1'b1;
                        cnt_n     = CNT_ONE;
                        ovf_n     = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                        ovf_n = ovf_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign N        = n_q;
    assign overflow = ovf_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_freq_meter_gated.sv
// Bench for freq_meter_gated: random pulse trains scored against a cycle-level edge model.
module tb_freq_meter_gated;
    localparam int SYNC = 2;

    typedef struct {
        int c;
        int n;
        bit ov;
    } res_t;

    logic        clk = 1'b0;
    logic        reset, pulse, enable, mode;
    logic [15:0] gate_len;
    logic [15:0] n16;
    logic        v16, o16, b16;
    logic [7:0]  n8;
    logic        v8, o8, b8;

    int   cyc = 0, n_checks = 0, n_fail = 0;
    int   acts[$];
    int   sched[$];
    res_t obs16[$], obs8[$], exp_q[$];
    int   pmode = 0, pper = 4, ph = 0;

    always #5 clk = ~clk;

    freq_meter_gated #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk(clk), .reset(reset), .pulse(pulse), .enable(enable), .mode(mode),
        .gate_len(gate_len), .N(n16), .valid(v16), .overflow(o16), .busy(b16));

    freq_meter_gated #(.CNT_W(8), .GATE_W(16), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .reset(reset), .pulse(pulse), .enable(enable), .mode(mode),
        .gate_len(gate_len), .N(n8), .valid(v8), .overflow(o8), .busy(b8));

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic pulse_at(int c);
        if (pmode == 1) return (c >= ph) && (((c - ph) % pper) < pper / 2);
        if (pmode == 2) begin
            foreach (sched[i]) if (c == sched[i] || c == sched[i] + 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Window w spans edges acting at cycles [j0+2+w*g, j0+1+(w+1)*g]; result seen at the window end.
    function automatic void freq_model(int j0, int g, int nw);
        int lo, hi, c;
        res_t r;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            lo = j0 + 2 + w * g;
            hi = j0 + 1 + (w + 1) * g;
            c  = 0;
            foreach (acts[i]) if (acts[i] >= lo && acts[i] <= hi) c++;
            r.c = hi; r.n = c; r.ov = 1'b0;
            exp_q.push_back(r);
        end
    endfunction

    // First edge after arming starts timing; every later edge reports distance to the previous one.
    function automatic void per_model(int j0, int e);
        int prev;
        res_t r;
        prev = -1;
        exp_q.delete();
        foreach (acts[i]) begin
            if (acts[i] >= j0 + 2 && acts[i] <= e) begin
                if (prev >= 0) begin
                    r.c = acts[i]; r.n = acts[i] - prev; r.ov = 1'b0;
                    exp_q.push_back(r);
                end
                prev = acts[i];
            end
        end
    endfunction

    // Advance one clock: sample outputs after the edge, then drive the next pulse level.
    task automatic tick();
        logic nxt;
        res_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (v16) begin r.c = cyc; r.n = int'(n16); r.ov = o16; obs16.push_back(r); end
        if (v8)  begin r.c = cyc; r.n = int'(n8);  r.ov = o8;  obs8.push_back(r);  end
        nxt = pulse_at(cyc);
        if (nxt && !pulse) acts.push_back(cyc + 1 + SYNC);
        pulse = nxt;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; mode = 1'b0; gate_len = 16'd10; pulse = 1'b0; pmode = 0;
        repeat (3) tick();
        n_checks++;
        if ({n16, v16, o16, b16} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset16: got N=%0d v=%b o=%b busy=%b expected all 0", n16, v16, o16, b16);
        end
        n_checks++;
        if ({n8, v8, o8, b8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got N=%0d v=%b o=%b busy=%b expected all 0", n8, v8, o8, b8);
        end
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (b16 !== 1'b0 || obs16.size() != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b results=%0d expected 0/0", b16, obs16.size());
        end
    endtask

    task automatic test_freq(string name, int g, int p, int nw);
        int j0, geff, e;
        geff = (g == 0) ? 1 : g;
        pmode = 1; pper = p; ph = cyc + 1 + int'($urandom_range(p - 1, 0));
        gate_len = 16'(g); mode = 1'b0;
        obs16.delete(); obs8.delete();
        j0 = cyc; enable = 1'b1;
        tick();
        mode = 1'b1;
        e = j0 + 1 + nw * geff;
        while (cyc < e) tick();
        enable = 1'b0;
        repeat (3) tick();
        freq_model(j0, geff, nw);
        n_checks++;
        if (obs16.size() != exp_q.size() || obs8.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d/%0d results expected %0d", name, obs16.size(), obs8.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs16.size() && i < obs8.size(); i++) begin
            n_checks++;
            if (obs16[i].c != exp_q[i].c || obs16[i].n != sat(exp_q[i].n, 65535) || obs16[i].ov != (exp_q[i].n > 65535)) begin
                n_fail++;
                $display("FAIL %s_w16[%0d]: got cyc=%0d N=%0d ov=%b expected cyc=%0d N=%0d ov=%b", name, i,
                         obs16[i].c, obs16[i].n, obs16[i].ov, exp_q[i].c, sat(exp_q[i].n, 65535), exp_q[i].n > 65535);
            end
            n_checks++;
            if (obs8[i].c != exp_q[i].c || obs8[i].n != sat(exp_q[i].n, 255) || obs8[i].ov != (exp_q[i].n > 255)) begin
                n_fail++;
                $display("FAIL %s_w8[%0d]: got cyc=%0d N=%0d ov=%b expected cyc=%0d N=%0d ov=%b", name, i,
                         obs8[i].c, obs8[i].n, obs8[i].ov, exp_q[i].c, sat(exp_q[i].n, 255), exp_q[i].n > 255);
            end
        end
    endtask

    task automatic test_period(string name, int p1, int p2, int t1, int t2);
        int j0, e;
        pmode = 1; pper = p1; ph = cyc + 1 + int'($urandom_range(p1 - 1, 0));
        mode = 1'b1; gate_len = 16'($urandom);
        obs16.delete(); obs8.delete();
        j0 = cyc; enable = 1'b1;
        tick();
        mode = 1'b0; gate_len = 16'($urandom);
        repeat (t1 - 1) tick();
        if (p2 != p1) begin pper = p2; ph = cyc + 2; end
        repeat (t2) tick();
        e = cyc; enable = 1'b0;
        repeat (3) tick();
        per_model(j0, e);
        n_checks++;
        if (obs16.size() != exp_q.size() || obs8.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d/%0d results expected %0d", name, obs16.size(), obs8.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs16.size() && i < obs8.size(); i++) begin
            n_checks++;
            if (obs16[i].c != exp_q[i].c || obs16[i].n != sat(exp_q[i].n, 65535) || obs16[i].ov != (exp_q[i].n > 65535)) begin
                n_fail++;
                $display("FAIL %s_p16[%0d]: got cyc=%0d N=%0d ov=%b expected cyc=%0d N=%0d ov=%b", name, i,
                         obs16[i].c, obs16[i].n, obs16[i].ov, exp_q[i].c, sat(exp_q[i].n, 65535), exp_q[i].n > 65535);
            end
            n_checks++;
            if (obs8[i].c != exp_q[i].c || obs8[i].n != sat(exp_q[i].n, 255) || obs8[i].ov != (exp_q[i].n > 255)) begin
                n_fail++;
                $display("FAIL %s_p8[%0d]: got cyc=%0d N=%0d ov=%b expected cyc=%0d N=%0d ov=%b", name, i,
                         obs8[i].c, obs8[i].n, obs8[i].ov, exp_q[i].c, sat(exp_q[i].n, 255), exp_q[i].n > 255);
            end
        end
    endtask

    // Edges placed on the last cycle of window 0 and the first cycle of window 2.
    task automatic test_gate_boundary();
        int j0, g;
        int exp_c[3], exp_n[3];
        g = 50;
        pmode = 0;
        repeat (4) tick();
        j0 = cyc + 3;
        sched.delete();
        sched.push_back(j0 - 1);
        sched.push_back(j0 + g - 2);
        sched.push_back(j0 + 2 * g - 1);
        sched.push_back(j0 + 3 * g - 2);
        pmode = 2;
        while (cyc < j0) tick();
        mode = 1'b0; gate_len = 16'(g);
        obs16.delete(); obs8.delete();
        enable = 1'b1;
        while (cyc < j0 + 1 + 3 * g) tick();
        enable = 1'b0;
        repeat (3) tick();
        pmode = 0;
        exp_c[0] = j0 + 1 + g;     exp_n[0] = 2;
        exp_c[1] = j0 + 1 + 2 * g; exp_n[1] = 0;
        exp_c[2] = j0 + 1 + 3 * g; exp_n[2] = 2;
        n_checks++;
        if (obs16.size() != 3) begin
            n_fail++;
            $display("FAIL boundary_count: got %0d results expected 3", obs16.size());
        end
        for (int i = 0; i < 3 && i < obs16.size(); i++) begin
            n_checks++;
            if (obs16[i].c != exp_c[i] || obs16[i].n != exp_n[i] || obs16[i].ov != 1'b0) begin
                n_fail++;
                $display("FAIL boundary[%0d]: got cyc=%0d N=%0d ov=%b expected cyc=%0d N=%0d ov=0", i,
                         obs16[i].c, obs16[i].n, obs16[i].ov, exp_c[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_enable_abort();
        int j0;
        pmode = 1; pper = 100; ph = cyc + 1;
        gate_len = 16'd1000; mode = 1'b0;
        obs16.delete(); obs8.delete();
        j0 = cyc; enable = 1'b1;
        while (cyc < j0 + 1001) tick();
        n_checks++;
        if (obs16.size() != 1 || n16 !== 16'd10) begin
            n_fail++;
            $display("FAIL abort_first: got results=%0d N=%0d expected 1/10", obs16.size(), n16);
        end
        repeat (499) tick();
        n_checks++;
        if (b16 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_mid: got %b expected 1", b16);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (b16 !== 1'b0 || b8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b/%b expected 0/0", b16, b8);
        end
        repeat (1100) tick();
        n_checks++;
        if (obs16.size() != 1 || n16 !== 16'd10 || o16 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold: got results=%0d N=%0d ov=%b expected 1/10/0", obs16.size(), n16, o16);
        end
    endtask

    task automatic test_async_reset();
        int j0, r;
        pmode = 1; pper = 20; ph = cyc + 1;
        gate_len = 16'd200; mode = 1'b0;
        obs16.delete(); obs8.delete();
        j0 = cyc; enable = 1'b1;
        repeat (230) tick();
        n_checks++;
        if (obs16.size() != 1 || n16 !== 16'd10) begin
            n_fail++;
            $display("FAIL rst_pre: got results=%0d N=%0d expected 1/10", obs16.size(), n16);
        end
        pmode = 0;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({n16, v16, o16, b16} !== 19'd0 || {n8, v8, o8, b8} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_async: got N=%0d v=%b o=%b busy=%b expected all 0", n16, v16, o16, b16);
        end
        repeat (3) tick();
        obs16.delete(); obs8.delete();
        r = cyc; reset = 1'b0;
        pmode = 1; ph = cyc + 1 + int'($urandom_range(19, 0));
        while (cyc < r + 205) tick();
        enable = 1'b0;
        repeat (3) tick();
        freq_model(r, 200, 1);
        n_checks++;
        if (obs16.size() != 1) begin
            n_fail++;
            $display("FAIL rst_count: got %0d results expected 1", obs16.size());
        end else begin
            n_checks++;
            if (obs16[0].c != exp_q[0].c || obs16[0].n != exp_q[0].n) begin
                n_fail++;
                $display("FAIL rst_first: got cyc=%0d N=%0d expected cyc=%0d N=%0d",
                         obs16[0].c, obs16[0].n, exp_q[0].c, exp_q[0].n);
            end
        end
    endtask

    initial begin
        reset = 1'b1; pulse = 1'b0; enable = 1'b0; mode = 1'b0; gate_len = '0;
        test_reset();
        test_freq("freq_1000", 1000, 100, 3);
        for (int k = 0; k < 3; k++)
            test_freq("freq_rand", int'($urandom_range(200, 10)), int'($urandom_range(60, 4)), 4);
        test_freq("freq_sat8", 1200, 4, 2);
        test_freq("freq_gate0", 0, 6, 15);
        test_gate_boundary();
        test_period("period_126", 126, 126, 400, 400);
        test_period("period_sat8", 300, 100, 1000, 500);
        for (int k = 0; k < 3; k++)
            test_period("period_rand", int'($urandom_range(400, 5)), int'($urandom_range(400, 5)), 900, 900);
        test_enable_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
